// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: op encodings and FSM state type.
package shift_pkg;
    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_e;
endpackage

// File: rtl/shift_unit.sv
// Combinational 32-bit-class barrel shifter: SLL/SRL/SRA/ROR, no state.
module shift_unit
    import shift_pkg::*;
#(
    parameter int DATA_W  = 32,
    localparam int SHAMT_W = $clog2(DATA_W)
) (
    input  logic [1:0]         op,
    input  logic [DATA_W-1:0]  x,
    input  logic [SHAMT_W-1:0] s,
    output logic [DATA_W-1:0]  z
);
    logic [2*DATA_W-1:0] rot_dbl;

    // Rotating the doubled word keeps s=0 exact without a wide left shift.
    assign rot_dbl = {x, x} >> s;

    always_comb begin
        z = x;
        case (shift_op_e'(op))
            OP_SLL:  z = x << s;
            OP_SRL:  z = x >> s;
            OP_SRA:  z = $unsigned($signed(x) >>> s);
            OP_ROR:  z = rot_dbl[DATA_W-1:0];
            default: z = x;
        endcase
    end
endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_unit between two requesters.
// Optional grant counters are enabled by defining SHIFT_ARB_PERF_EN.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int DATA_W  = 32,
    localparam int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [1:0]         req0_op,
    input  logic [DATA_W-1:0]  req0_x,
    input  logic [SHAMT_W-1:0] req0_s,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [1:0]         req1_op,
    input  logic [DATA_W-1:0]  req1_x,
    input  logic [SHAMT_W-1:0] req1_s,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic [DATA_W-1:0]  resp_z
`ifdef SHIFT_ARB_PERF_EN
    ,
    output logic [15:0]        perf_grant0,
    output logic [15:0]        perf_grant1
`endif
);
    arb_state_e         state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [1:0]         op_q, op_d;
    logic [DATA_W-1:0]  x_q, x_d;
    logic [SHAMT_W-1:0] s_q, s_d;
    logic               id_q, id_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_id_q, resp_id_d;
    logic [DATA_W-1:0]  resp_z_q, resp_z_d;

    logic               any_req;
    logic               gnt;
    logic               grant_fire;
    logic [DATA_W-1:0]  z;

    assign any_req = req0_valid | req1_valid;
    // Contention goes to whoever was not served last; otherwise the sole requester.
    assign gnt = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    assign grant_fire = (state_q == IDLE) & any_req;

    shift_unit #(.DATA_W(DATA_W)) u_shift (
        .op (op_q),
        .x  (x_q),
        .s  (s_q),
        .z  (z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            x_q          <= '0;
            s_q          <= '0;
            id_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_z_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            x_q          <= x_d;
            s_q          <= s_d;
            id_q         <= id_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_z_q     <= resp_z_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        x_d          = x_q;
        s_d          = s_q;
        id_d         = id_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_z_d     = resp_z_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    req0_ready   = ~gnt;
                    req1_ready   = gnt;
                    op_d         = gnt ? req1_op : req0_op;
                    x_d          = gnt ? req1_x  : req0_x;
                    s_d          = gnt ? req1_s  : req0_s;
                    id_d         = gnt;
                    last_grant_d = gnt;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                resp_z_d     = z;
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_z     = resp_z_q;

`ifdef SHIFT_ARB_PERF_EN
    logic [15:0] perf0_q, perf1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf0_q <= '0;
            perf1_q <= '0;
        end else if (grant_fire) begin
            if (!gnt && perf0_q != 16'hFFFF) perf0_q <= perf0_q + 16'd1;
            if (gnt && perf1_q != 16'hFFFF)  perf1_q <= perf1_q + 16'd1;
        end
    end

    assign perf_grant0 = perf0_q;
    assign perf_grant1 = perf1_q;
`else
    logic unused_fire;
    assign unused_fire = grant_fire;
`endif
endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: stimulus pushes expected responses, monitor pops.
module tb_shift_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_x, req1_x;
    logic [4:0]  req0_s, req1_s;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_z;
`ifdef SHIFT_ARB_PERF_EN
    logic [15:0] perf_grant0, perf_grant1;
`endif

    typedef struct packed {
        logic        id;
        logic [31:0] z;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    shift_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_x(req0_x), .req0_s(req0_s),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_x(req1_x), .req1_s(req1_s),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_z(resp_z)
`ifdef SHIFT_ARB_PERF_EN
        , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every completed response handshake is matched against the queue head.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=%h/%0d required=none", resp_z, resp_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_id", {31'd0, resp_id}, {31'd0, e.id});
                chk("resp_z", resp_z, e.z);
            end
        end
    end

    task automatic set_req(input logic id, input logic [1:0] op, input logic [31:0] x,
                           input logic [4:0] s);
        if (id) begin req1_valid = 1'b1; req1_op = op; req1_x = x; req1_s = s; end
        else    begin req0_valid = 1'b1; req0_op = op; req0_x = x; req0_s = s; end
    endtask

    // Issue on one port, return 1 time unit after the handshake edge.
    task automatic issue(input logic id, input logic [1:0] op, input logic [31:0] x,
                         input logic [4:0] s, input logic [31:0] ez);
        bit ok = 0;
        exp_q.push_back('{id: id, z: ez});
        set_req(id, op, x, s);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = id ? req1_ready : req0_ready;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL issue_timeout actual=noready required=ready id=%0d", id);
        end
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    // Wait for readies while both ports request, dropping each valid after its handshake.
    task automatic serve_both();
        bit d0 = 0, d1 = 0, r0, r1;
        for (int i = 0; i < 60 && !(d0 && d1); i++) begin
            @(negedge clk);
            r0 = req0_ready && !d0;
            r1 = req1_ready && !d1;
            if (req0_ready && req1_ready) begin
                checks++; errors++;
                $display("FAIL double_grant actual=11 required=one-hot");
            end
            @(posedge clk); #1;
            if (r0) begin req0_valid = 1'b0; d0 = 1; end
            if (r1) begin req1_valid = 1'b0; d1 = 1; end
        end
        if (!(d0 && d1)) begin
            checks++; errors++;
            $display("FAIL both_timeout actual=%0d%0d required=11", d0, d1);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; resp_ready = 1'b1;
        req0_valid = 0; req0_op = 0; req0_x = 0; req0_s = 0;
        req1_valid = 0; req1_op = 0; req1_x = 0; req1_s = 0;
        #2;
        chk("rst_resp_valid", {31'd0, resp_valid}, 0);
        chk("rst_resp_z", resp_z, 0);
        chk("rst_resp_id", {31'd0, resp_id}, 0);
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: SRA sign fill, plus latency
        issue(0, 2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000);
        @(negedge clk); chk("lat_exec_valid", {31'd0, resp_valid}, 0);
        @(negedge clk); chk("lat_resp_valid", {31'd0, resp_valid}, 1);
        drain();

        // 2: both valid after reset, req0 first
        do_reset();
        exp_q.push_back('{id: 1'b0, z: 32'h8000_0000});
        exp_q.push_back('{id: 1'b1, z: 32'h0000_0001});
        set_req(0, 2'b00, 32'h1, 5'd31);
        set_req(1, 2'b01, 32'h8000_0000, 5'd31);
        serve_both();
        drain();

        // 3: response back-pressure
        resp_ready = 1'b0;
        issue(0, 2'b01, 32'hF000_0000, 5'd4, 32'h0F00_0000);
        exp_q.push_back('{id: 1'b1, z: 32'h0000_FF00});
        set_req(1, 2'b00, 32'h0000_00FF, 5'd8);
        for (int i = 0; i < 10 && !resp_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, resp_valid}, 1);
            chk("hold_z", resp_z, 32'h0F00_0000);
            chk("hold_id", {31'd0, resp_id}, 0);
            chk("hold_ready", {30'd0, req1_ready, req0_ready}, 0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        for (int i = 0; i < 20 && !req1_ready; i++) @(negedge clk);
        chk("pending_ready", {31'd0, req1_ready}, 1);
        @(posedge clk); #1 req1_valid = 1'b0;
        drain();

        // 4: rotate and zero shifts
        issue(1, 2'b11, 32'h0000_0001, 5'd1, 32'h8000_0000);
        issue(0, 2'b00, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
        issue(0, 2'b10, 32'h7000_0000, 5'd4, 32'h0700_0000);
        issue(1, 2'b11, 32'h1234_5678, 5'd8, 32'h7812_3456);
        issue(1, 2'b01, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
        drain();

        // 5: reset mid-EXEC drops the op; req0 wins next
        issue(0, 2'b01, 32'hFFFF_FFFF, 5'd1, 32'h0);
        void'(exp_q.pop_back());
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, resp_valid}, 0);
        chk("midrst_z", resp_z, 0);
        chk("midrst_id", {31'd0, resp_id}, 0);
        chk("midrst_ready", {30'd0, req1_ready, req0_ready}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.push_back('{id: 1'b0, z: 32'hFFFF_FFFF});
        exp_q.push_back('{id: 1'b1, z: 32'h0000_0002});
        set_req(0, 2'b10, 32'h8000_0001, 5'd31);
        set_req(1, 2'b11, 32'h0000_0001, 5'd31);
        serve_both();
        drain();

        // 6: more grants for counter totals (req0 3, req1 2 since reset)
        issue(0, 2'b00, 32'h3, 5'd2, 32'hC);
        issue(0, 2'b00, 32'h1, 5'd1, 32'h2);
        issue(1, 2'b01, 32'h100, 5'd4, 32'h10);
        drain();
`ifdef SHIFT_ARB_PERF_EN
        chk("perf_grant0", {16'd0, perf_grant0}, 3);
        chk("perf_grant1", {16'd0, perf_grant1}, 2);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
